// File: rtl/moving_average_n_pkg.sv
// Shared types and bit-vector conversion helpers for the moving-average filter.
// The types describe the default 8-bit / 4-tap configuration.
package moving_average_n_types;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_L     = $clog2(DEF_DEPTH);

  typedef logic signed [DEF_WIDTH-1:0]       sample_t;
  typedef sample_t     [DEF_DEPTH-1:0]       window_t;
  typedef logic signed [DEF_WIDTH+DEF_L-1:0] sum_t;

  function automatic logic [DEF_WIDTH-1:0] sample_to_lv(input sample_t s);
    return s;
  endfunction

  function automatic logic [DEF_DEPTH*DEF_WIDTH-1:0] window_to_lv(input window_t w);
    return w;
  endfunction

  function automatic logic [DEF_WIDTH+DEF_L-1:0] sum_to_lv(input sum_t s);
    return s;
  endfunction

endpackage

// File: rtl/moving_average_n_window.sv
// Circular sample buffer with write pointer and saturating fill count.
// The slot about to be overwritten is presented combinationally as the evicted sample.
module moving_average_n_window
  import moving_average_n_types::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int L    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] data,
  output logic signed [WIDTH-1:0] oldest,
  output logic [L:0]              fill
);

  localparam logic [L:0] FULL = (L+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [L-1:0]                wp;

  assign oldest = mem[wp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem  <= '0;
      wp   <= '0;
      fill <= '0;
    end else if (clear) begin
      mem  <= '0;
      wp   <= '0;
      fill <= '0;
    end else if (push) begin
      mem[wp] <= data;
      // DEPTH is a power of two, so the pointer wraps by natural overflow
      wp      <= wp + L'(1);
      if (fill != FULL) fill <= fill + (L+1)'(1);
    end
  end

endmodule

// File: rtl/moving_average_n.sv
// Streaming moving-average filter: running sum of the last DEPTH samples,
// divided by DEPTH with floor or round-half-up, one cycle of latency.
module moving_average_n
  import moving_average_n_types::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ROUND = 0,
  localparam int L    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [WIDTH-1:0]   in_data,
  input  logic                      clear,
  output logic                      out_valid,
  output logic signed [WIDTH-1:0]   out_data,
  output logic signed [WIDTH+L-1:0] out_sum,
  output logic                      window_full
);

  localparam int SW         = WIDTH + L;
  localparam int BIAS       = (ROUND != 0) ? (1 << (L - 1)) : 0;
  localparam logic [L:0] FULL = (L+1)'(DEPTH);

  logic signed [WIDTH-1:0] oldest;
  logic [L:0]              fill;
  logic signed [SW-1:0]    acc, acc_next, in_ext, old_ext;
  logic signed [SW:0]      rnd;
  logic                    accept;
  logic                    unused_rnd_bits;

  assign accept = in_valid & ~clear;

  moving_average_n_window #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_window (
    .clk    (clk),
    .rst    (rst),
    .push   (accept),
    .clear  (clear),
    .data   (in_data),
    .oldest (oldest),
    .fill   (fill)
  );

  assign in_ext   = {{L{in_data[WIDTH-1]}}, in_data};
  assign old_ext  = {{L{oldest[WIDTH-1]}}, oldest};
  assign acc_next = acc + in_ext - old_ext;

  // One extra bit keeps the rounding bias from wrapping at the positive extreme
  assign rnd = {acc_next[SW-1], acc_next} + (SW+1)'(BIAS);
  assign unused_rnd_bits = ^{rnd[SW], rnd[L-1:0]};

  assign window_full = (fill == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sum   <= '0;
    end else if (clear) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sum   <= '0;
    end else if (in_valid) begin
      acc       <= acc_next;
      out_valid <= 1'b1;
      out_data  <= rnd[SW-1:L];
      out_sum   <= acc_next;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_average_n.sv
// Bench for moving_average_n: directed vector table on a floor and a rounding
// instance sharing one input stream, async-reset check, then random traffic vs a queue model.
module tb_moving_average_n;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int L     = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      clear;
  logic signed [WIDTH-1:0]   in_data;
  logic                      v0, v1, f0, f1;
  logic signed [WIDTH-1:0]   d0, d1;
  logic signed [WIDTH+L-1:0] s0, s1;

  moving_average_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ROUND(0)) dut_floor (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .out_valid(v0), .out_data(d0), .out_sum(s0), .window_full(f0)
  );

  moving_average_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ROUND(1)) dut_round (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .out_valid(v1), .out_data(d1), .out_sum(s1), .window_full(f1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of samples in the window, summed directly
  int mq[$];
  int m_sum, m_floor, m_round, m_cnt;
  bit m_valid, m_full;

  typedef struct {
    bit v; bit c; int d;
    int sum; int dat_floor; int dat_round; bit full; bit valid;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int floor_div(input int num, input int den);
    int q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_sum = 0; m_floor = 0; m_round = 0; m_cnt = 0;
    m_valid = 0; m_full = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    if (c) begin
      model_reset();
    end else if (v) begin
      mq.push_back(d);
      if (mq.size() > DEPTH) void'(mq.pop_front());
      m_sum = 0;
      foreach (mq[i]) m_sum += mq[i];
      m_floor = floor_div(m_sum, DEPTH);
      m_round = floor_div(2 * m_sum + DEPTH, 2 * DEPTH);
      m_cnt   = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    m_full = (m_cnt == DEPTH);
  endtask

  task automatic step(input bit v, input int d, input bit c);
    in_valid = v;
    in_data  = WIDTH'(d);
    clear    = c;
    @(posedge clk);
    #1;
    model_step(v, d, c);
  endtask

  task automatic add(input bit v, input bit c, input int d, input int sum,
                     input int df, input int dr, input bit full, input bit valid);
    vec_t e;
    e.v = v; e.c = c; e.d = d; e.sum = sum;
    e.dat_floor = df; e.dat_round = dr; e.full = full; e.valid = valid;
    tbl.push_back(e);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid_floor"}, int'(v0), int'(m_valid));
    chk({tag, " valid_round"}, int'(v1), int'(m_valid));
    chk({tag, " sum_floor"},   int'(s0), m_sum);
    chk({tag, " sum_round"},   int'(s1), m_sum);
    chk({tag, " data_floor"},  int'(d0), m_floor);
    chk({tag, " data_round"},  int'(d1), m_round);
    chk({tag, " full_floor"},  int'(f0), int'(m_full));
    chk({tag, " full_round"},  int'(f1), int'(m_full));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; in_data = '0;
    model_reset();

    // Ramp 4..20, window fills on the fourth output
    add(1,0,  4,   4,  1,  1,0,1);
    add(1,0,  8,  12,  3,  3,0,1);
    add(1,0, 12,  24,  6,  6,0,1);
    add(1,0, 16,  40, 10, 10,1,1);
    add(1,0, 20,  56, 14, 14,1,1);
    // Clear beats a simultaneous sample
    add(1,1, 99,   0,  0,  0,0,0);
    // Gaps hold the output
    add(1,0,  8,   8,  2,  2,0,1);
    add(0,0,  0,   8,  2,  2,0,0);
    add(0,0,  0,   8,  2,  2,0,0);
    add(0,0,  0,   8,  2,  2,0,0);
    add(1,0,  8,  16,  4,  4,0,1);
    // Clear at the third sample of 4,8,12
    add(0,1,  0,   0,  0,  0,0,0);
    add(1,0,  4,   4,  1,  1,0,1);
    add(1,0,  8,  12,  3,  3,0,1);
    add(1,1, 12,   0,  0,  0,0,0);
    add(1,0,  4,   4,  1,  1,0,1);
    // Rounding of small signed sums
    add(0,1,  0,   0,  0,  0,0,0);
    add(1,0, -1,  -1, -1,  0,0,1);
    add(1,0,  2,   1,  0,  0,0,1);
    add(1,0,  1,   2,  0,  1,0,1);
    // Extremes with pointer wrap
    add(0,1,  0,   0,  0,  0,0,0);
    add(1,0,127, 127, 31, 32,0,1);
    add(1,0,127, 254, 63, 64,0,1);
    add(1,0,127, 381, 95, 95,0,1);
    add(1,0,127, 508,127,127,1,1);
    add(1,0,127, 508,127,127,1,1);
    add(1,0,127, 508,127,127,1,1);
    add(1,0,-128, 253, 63, 63,1,1);
    add(1,0,-128,  -2, -1,  0,1,1);
    add(1,0,-128,-257,-65,-64,1,1);
    add(1,0,-128,-512,-128,-128,1,1);
    add(1,0,-128,-512,-128,-128,1,1);
    add(1,0,-128,-512,-128,-128,1,1);

    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      step(tbl[k].v, tbl[k].d, tbl[k].c);
      chk({tag, " valid"},      int'(v0), int'(tbl[k].valid));
      chk({tag, " valid_r"},    int'(v1), int'(tbl[k].valid));
      chk({tag, " sum"},        int'(s0), tbl[k].sum);
      chk({tag, " sum_r"},      int'(s1), tbl[k].sum);
      chk({tag, " data_floor"}, int'(d0), tbl[k].dat_floor);
      chk({tag, " data_round"}, int'(d1), tbl[k].dat_round);
      chk({tag, " full"},       int'(f0), int'(tbl[k].full));
      chk({tag, " full_r"},     int'(f1), int'(tbl[k].full));
    end

    // Asynchronous reset mid-stream, observed before any further clock edge
    step(1, 37, 0);
    step(1, -50, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // window_full must stay low until DEPTH fresh samples
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1, 10 * i - 20, 0);
      check_model($sformatf("refill%0d", i));
    end

    for (int i = 0; i < 400; i++) begin
      bit v, c;
      int d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      d = int'($urandom_range(0, 255)) - 128;
      step(v, d, c);
      check_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
